// File: rtl/spi_mem_pkg.sv
// rtl/spi_mem_pkg.sv - shared types and constants for the SPI memory controller
package spi_mem_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   localparam logic [7:0] CMD_READ  = 8'h03;
   localparam logic [7:0] CMD_WRITE = 8'h02;
   localparam int         DATA_BITS = 32;

   // Wire byte order is little-endian: the byte at the lowest address travels first.
   function automatic logic [31:0] byte_swap32(input logic [31:0] w);
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
   endfunction

endpackage

// File: rtl/spi_mem_shifter.sv
// rtl/spi_mem_shifter.sv - SPI mode-0 bit engine: TX/RX shift registers and bit counter
module spi_mem_shifter
   import spi_mem_pkg::*;
#(
   parameter int FRAME_BITS = 64
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_load,
   input  logic [FRAME_BITS-1:0] i_frame,
   input  logic                  i_active,
   input  logic                  i_miso,
   output logic                  o_last,
   output logic [DATA_BITS-1:0]  o_rx_next,
   output logic                  o_sclk,
   output logic                  o_mosi
);

   localparam int               CNT_W    = $clog2(FRAME_BITS);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_BITS - 1);

   // The frame MSB goes straight to the mosi flop at load, so only the rest is kept here.
   logic [FRAME_BITS-2:0] r_tx;
   logic [DATA_BITS-1:0]  r_rx;
   logic [CNT_W-1:0]      r_cnt;
   logic                  r_phase;
   logic                  r_sclk;
   logic                  r_mosi;
   logic                  w_last_bit;

   assign w_last_bit = (r_cnt == LAST_CNT);
   assign o_last     = i_active && r_phase && w_last_bit;
   assign o_rx_next  = {r_rx[DATA_BITS-2:0], i_miso};
   assign o_sclk     = r_sclk;
   assign o_mosi     = r_mosi;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tx    <= '0;
         r_rx    <= '0;
         r_cnt   <= '0;
         r_phase <= 1'b0;
         r_sclk  <= 1'b0;
         r_mosi  <= 1'b0;
      end else if (i_load) begin
         r_tx    <= i_frame[FRAME_BITS-2:0];
         r_cnt   <= '0;
         r_phase <= 1'b0;
         r_sclk  <= 1'b0;
         r_mosi  <= i_frame[FRAME_BITS-1];
      end else if (i_active && !r_phase) begin
         r_phase <= 1'b1;
         r_sclk  <= 1'b1;
      end else if (i_active) begin
         // End of the sclk-high phase: sample MISO, then present the next bit.
         r_rx    <= o_rx_next;
         r_phase <= 1'b0;
         r_sclk  <= 1'b0;
         if (w_last_bit) begin
            r_mosi <= 1'b0;
         end else begin
            r_cnt  <= r_cnt + CNT_W'(1);
            r_mosi <= r_tx[FRAME_BITS-2];
            r_tx   <= {r_tx[FRAME_BITS-3:0], 1'b0};
         end
      end else begin
         r_phase <= 1'b0;
         r_sclk  <= 1'b0;
         r_mosi  <= 1'b0;
      end
   end

endmodule

// File: rtl/spi_mem_ctrl.sv
// rtl/spi_mem_ctrl.sv - core-side request FSM driving a 32-bit SPI memory read/write frame
module spi_mem_ctrl
   import spi_mem_pkg::*;
#(
   parameter int ADDR_W = 24
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              req_ready,
   output logic              rsp_valid,
   output logic [31:0]       rsp_rdata,
   output logic              spi_cs_n,
   output logic              spi_sclk,
   output logic              spi_mosi,
   input  logic              spi_miso
);

   localparam int FRAME_BITS = 8 + ADDR_W + DATA_BITS;

   state_t                r_state;
   state_t                w_next_state;
   logic                  w_load;
   logic                  w_active;
   logic                  w_last;
   logic [7:0]            w_cmd;
   logic [31:0]           w_wire_data;
   logic [FRAME_BITS-1:0] w_frame;
   logic [DATA_BITS-1:0]  w_rx_next;
   logic                  r_write;
   logic                  r_cs_n;
   logic [31:0]           r_rdata;

   assign w_cmd       = req_write ? CMD_WRITE : CMD_READ;
   assign w_wire_data = req_write ? byte_swap32(req_wdata) : 32'h0;
   assign w_frame     = {w_cmd, req_addr, w_wire_data};
   assign spi_cs_n    = r_cs_n;
   assign rsp_rdata   = r_rdata;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE:  if (req_valid) w_next_state = ST_SHIFT;
         ST_SHIFT: if (w_last) w_next_state = ST_DONE;
         ST_DONE:  w_next_state = ST_IDLE;
         default:  w_next_state = ST_IDLE;
      endcase
   end

   always_comb begin
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      w_load    = 1'b0;
      w_active  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            req_ready = 1'b1;
            w_load    = req_valid;
         end
         ST_SHIFT: w_active  = 1'b1;
         ST_DONE:  rsp_valid = 1'b1;
         default:  ;
      endcase
   end

   // cs_n follows the next state so it is a flop that is low for exactly the SHIFT cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cs_n  <= 1'b1;
         r_write <= 1'b0;
         r_rdata <= '0;
      end else begin
         r_cs_n <= (w_next_state != ST_SHIFT);
         if (w_load) begin
            r_write <= req_write;
         end
         if (w_last && !r_write) begin
            r_rdata <= byte_swap32(w_rx_next);
         end
      end
   end

   spi_mem_shifter #(
      .FRAME_BITS (FRAME_BITS)
   ) u_shifter (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_load    (w_load),
      .i_frame   (w_frame),
      .i_active  (w_active),
      .i_miso    (spi_miso),
      .o_last    (w_last),
      .o_rx_next (w_rx_next),
      .o_sclk    (spi_sclk),
      .o_mosi    (spi_mosi)
   );

endmodule

// File: tb/tb_spi_mem_ctrl.sv
// tb/tb_spi_mem_ctrl.sv - directed bench for spi_mem_ctrl with a clocked SPI memory model
module tb_spi_mem_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_write;
   logic [23:0] req_addr;
   logic [31:0] req_wdata;
   logic        req_ready;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        spi_cs_n;
   logic        spi_sclk;
   logic        spi_mosi;
   logic        miso_r = 1'b0;

   int n_chk  = 0;
   int n_pass = 0;

   // Memory model / protocol monitor state, all owned by the negedge process.
   logic        p_cs_n = 1'b1;
   logic        p_sclk = 1'b0;
   logic        p_mosi = 1'b0;
   logic [63:0] m_rx = '0;
   logic [31:0] m_miso_data = '0;
   int m_cnt    = 0;
   int m_frames = 0;
   int m_rsp    = 0;
   int m_proto  = 0;
   int m_hi_run = 0;
   int m_gap    = 0;

   always #5 clk = ~clk;

   spi_mem_ctrl dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_write (req_write),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .spi_cs_n  (spi_cs_n),
      .spi_sclk  (spi_sclk),
      .spi_mosi  (spi_mosi),
      .spi_miso  (miso_r)
   );

   always @(negedge clk) begin
      if (spi_cs_n) begin
         if (spi_sclk !== 1'b0 || spi_mosi !== 1'b0) m_proto++;
         m_hi_run++;
         miso_r = 1'b0;
      end else begin
         if (p_cs_n) begin
            m_frames++;
            m_gap = m_hi_run;
            m_rx  = '0;
            m_cnt = 0;
            if (spi_sclk !== 1'b0) m_proto++;
         end else if (spi_sclk === p_sclk) begin
            m_proto++;
         end
         m_hi_run = 0;
         if (spi_sclk && !p_sclk) begin
            if (!p_cs_n && spi_mosi !== p_mosi) m_proto++;
            m_rx = {m_rx[62:0], spi_mosi};
            m_cnt++;
         end
         if (!spi_sclk) begin
            miso_r = (m_cnt >= 32 && m_cnt < 64) ? m_miso_data[5'(63 - m_cnt)] : 1'b0;
         end
      end
      if (rsp_valid) m_rsp++;
      p_cs_n = spi_cs_n;
      p_sclk = spi_sclk;
      p_mosi = spi_mosi;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic issue(input logic wr, input logic [23:0] a, input logic [31:0] d);
      req_valid = 1'b1;
      req_write = wr;
      req_addr  = a;
      req_wdata = d;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
   endtask

   task automatic wait_rsp(output int lat);
      lat = 1;
      while (rsp_valid !== 1'b1 && lat < 300) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   int lat;
   int frames0;
   int rsp0;

   initial begin
      rst_n     = 1'b0;
      req_valid = 1'b0;
      req_write = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", req_ready, 1);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rdata", rsp_rdata, 0);
      check("rst_cs_n", spi_cs_n, 1);
      check("rst_sclk", spi_sclk, 0);
      check("rst_mosi", spi_mosi, 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Read at 0x000010, memory returns 78 56 34 12
      m_miso_data = 32'h78563412;
      check("rd_ready", req_ready, 1);
      issue(1'b0, 24'h000010, 32'h0);
      wait_rsp(lat);
      check("rd_latency", lat, 129);
      check("rd_rdata", rsp_rdata, 32'h12345678);
      check("rd_mosi_hdr", m_rx[63:32], 32'h03000010);
      check("rd_bit_count", m_cnt, 64);
      check("rd_done_cs_n", spi_cs_n, 1);
      @(posedge clk);
      #1;
      check("rd_pulse_end", rsp_valid, 0);
      check("rd_back_ready", req_ready, 1);

      // Write 0xDEADBEEF at 0x0000FC
      issue(1'b1, 24'h0000FC, 32'hDEADBEEF);
      wait_rsp(lat);
      check("wr_latency", lat, 129);
      check("wr_mosi_frame", m_rx, 64'h020000FC_EFBEADDE);
      check("wr_rdata_kept", rsp_rdata, 32'h12345678);
      @(posedge clk);
      #1;

      // Back-to-back reads with req_valid held high
      m_miso_data = 32'hA1B2C3D4;
      frames0     = m_frames;
      req_valid   = 1'b1;
      req_write   = 1'b0;
      req_addr    = 24'h000020;
      @(posedge clk);
      #1;
      wait_rsp(lat);
      check("b2b_a_latency", lat, 129);
      check("b2b_a_rdata", rsp_rdata, 32'hD4C3B2A1);
      m_miso_data = 32'h01020304;
      req_addr    = 24'h000024;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      wait_rsp(lat);
      check("b2b_b_latency", lat, 129);
      check("b2b_b_rdata", rsp_rdata, 32'h04030201);
      check("b2b_b_mosi_hdr", m_rx[63:32], 32'h03000024);
      check("b2b_cs_gap", m_gap, 2);
      check("b2b_frames", m_frames, frames0 + 2);
      @(posedge clk);
      #1;

      // req_valid toggling while the frame is shifting
      m_miso_data = 32'h55AA0FF0;
      frames0     = m_frames;
      rsp0        = m_rsp;
      issue(1'b0, 24'h000030, 32'h0);
      lat = 1;
      while (rsp_valid !== 1'b1 && lat < 300) begin
         req_valid = ~req_valid;
         req_write = lat[0];
         req_addr  = 24'(lat * 7);
         req_wdata = $urandom;
         @(posedge clk);
         #1;
         lat++;
      end
      req_valid = 1'b0;
      check("tog_latency", lat, 129);
      check("tog_rdata", rsp_rdata, 32'hF00FAA55);
      check("tog_mosi_hdr", m_rx[63:32], 32'h03000030);
      repeat (6) @(posedge clk);
      #1;
      check("tog_frames", m_frames, frames0 + 1);
      check("tog_rsp_count", m_rsp, rsp0 + 1);

      // Reset at cycle T+60 of a read
      m_miso_data = 32'h11111111;
      issue(1'b0, 24'h000040, 32'h0);
      lat = 1;
      while (lat < 60) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check("mid_cs_low", spi_cs_n, 0);
      rsp0  = m_rsp;
      rst_n = 1'b0;
      #1;
      check("arst_cs_n", spi_cs_n, 1);
      check("arst_sclk", spi_sclk, 0);
      check("arst_mosi", spi_mosi, 0);
      check("arst_rsp_valid", rsp_valid, 0);
      check("arst_ready", req_ready, 1);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (140) @(posedge clk);
      #1;
      check("arst_no_rsp", m_rsp, rsp0);
      check("arst_rdata_clr", rsp_rdata, 0);
      m_miso_data = 32'hCAFEF00D;
      issue(1'b0, 24'h000000, 32'h0);
      wait_rsp(lat);
      check("post_rst_latency", lat, 129);
      check("post_rst_rdata", rsp_rdata, 32'h0DF0FECA);
      check("post_rst_mosi_hdr", m_rx[63:32], 32'h03000000);
      @(posedge clk);
      #1;
      check("protocol_errors", m_proto, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/spi_mem_ctrl.md
SPI_MEM_CTRL -- requirements
Module: spi_mem_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 24, giving the external SPI memory address width in bits (must be a multiple of 8).
REQ-002 The block SHALL have port clk, input, 1, the single system clock.
REQ-003 The block SHALL have port rst_n, input, 1, an asynchronous active-low reset.
REQ-004 The block SHALL have port req_valid, input, 1, a memory request from the core.
REQ-005 The block SHALL have port req_write, input, 1, selecting write (1) or read (0).
REQ-006 The block SHALL have port req_addr, input, ADDR_W, the byte address.
REQ-007 The block SHALL have port req_wdata, input, 32, the write data.
REQ-008 The block SHALL have port req_ready, output, 1, high when a request can be accepted.
REQ-009 The block SHALL have port rsp_valid, output, 1, a one-cycle completion pulse.
REQ-010 The block SHALL have port rsp_rdata, output, 32, the read data.
REQ-011 The block SHALL have ports spi_cs_n (output, 1), spi_sclk (output, 1), spi_mosi (output, 1) and spi_miso (input, 1), forming the SPI memory bus (mode 0).

Function
REQ-012 States SHALL be IDLE, SHIFT and DONE, with transitions IDLE->SHIFT on req_valid&&req_ready, SHIFT->DONE after the last bit, and DONE->IDLE unconditionally.
REQ-013 req_ready SHALL be 1 only in IDLE; req_valid outside IDLE SHALL be ignored, and inputs SHALL be captured only at the accept edge.
REQ-014 Frame SHALL be 8-bit command (0x03 read, 0x02 write), then ADDR_W address bits, then 32 data bits, all MSB-first per byte and address MSB-first.
REQ-015 Data bytes SHALL be little-endian: byte at req_addr first, so wire bytes b0,b1,b2,b3 map to word {b3,b2,b1,b0}.
REQ-016 Each bit SHALL take 2 clk cycles: a low phase (sclk=0, mosi valid) and then a high phase (sclk=1).
REQ-017 MISO SHALL be sampled on the clk edge that ends the sclk-high phase.
REQ-018 spi_cs_n SHALL be low for exactly all SHIFT cycles: 2*(40+ADDR_W) cycles, i.e. 128 at default.
REQ-019 For an accept at edge T, SHIFT SHALL occupy cycles T+1..T+128 and DONE cycle T+129 (default ADDR_W).
REQ-020 In DONE, rsp_valid SHALL be 1, cs_n SHALL be 1 and sclk SHALL be 0.
REQ-021 In DONE after a read, rsp_rdata SHALL hold the assembled word.
REQ-022 On a write, rsp_valid SHALL pulse as an acknowledge and rsp_rdata SHALL keep its previous value.
REQ-023 Minimum cs_n high time between frames SHALL be 2 cycles (DONE plus IDLE), including back-to-back requests.
REQ-024 mosi SHALL be 0 whenever cs_n=1.
REQ-025 spi_sclk, spi_cs_n and spi_mosi SHALL be driven from flops (glitch-free).
REQ-026 Bit counter SHALL be sized for 40+ADDR_W bits and SHALL not wrap within a frame.

Reset
REQ-027 On rst_n low, regardless of state, the block SHALL asynchronously go to IDLE with req_ready=1, rsp_valid=0, rsp_rdata=0, spi_cs_n=1, spi_sclk=0 and spi_mosi=0.
REQ-028 A reset mid-frame SHALL abort it without a rsp_valid pulse; the first request after release SHALL start a fresh frame.

Structure
REQ-029 Shared package spi_mem_pkg SHALL hold the state enum, CMD_READ=8'h03, CMD_WRITE=8'h02 and DATA_BITS=32.
REQ-030 One sub-module, spi_mem_shifter, SHALL hold the parallel-load TX shift register, the RX shift register and the bit counter; the FSM and byte reordering SHALL stay in spi_mem_ctrl.

Verification
REQ-031 The bench SHALL cover a read at addr 0x000010 with the model returning 0x78,0x56,0x34,0x12 -> MOSI 0x03,0x00,0x00,0x10; rsp_rdata=0x12345678; rsp_valid at T+129.
REQ-032 The bench SHALL cover a write of 0xDEADBEEF at 0x0000FC -> MOSI 0x02,0x00,0x00,0xFC,0xEF,0xBE,0xAD,0xDE; rsp_valid pulse; rsp_rdata unchanged.
REQ-033 The bench SHALL cover two back-to-back reads with req_valid held high -> cs_n high exactly 2 cycles between frames; both responses correct.
REQ-034 The bench SHALL cover req_valid toggling during SHIFT -> no extra frame, no extra rsp_valid, and frame bits unchanged.
REQ-035 The bench SHALL cover rst_n low at cycle T+60 of a read -> cs_n=1 and sclk=0 immediately, no rsp_valid, and a following read of 0x000000 completes correctly.
REQ-036 The bench SHALL check throughout every frame that sclk toggles every cycle only while cs_n=0 and mosi is stable across each sclk-high phase.
